// File: rtl/shared_mult_sched_pkg.sv
// Shared defaults and types for the round-robin shared multiplier scheduler.
package pkg_shared_mult;

  localparam int NREQ_DEF  = 4;
  localparam int BITS_DEF  = 17;
  localparam int NFRAC_DEF = 8;
  localparam int IDW_DEF   = $clog2(NREQ_DEF);

  typedef logic [IDW_DEF-1:0]                   req_id_t;
  typedef logic signed [BITS_DEF-1:0]           weight_t;
  typedef logic signed [BITS_DEF+NFRAC_DEF-1:0] result_t;

  // Next round-robin position after idx, wrapping at n.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/shared_mult_sched_arb.sv
// Combinational round-robin arbiter: the scan starts at the pointer and wraps once.
module rr_arbiter
  import pkg_shared_mult::*;
#(
  parameter  int NREQ = NREQ_DEF,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);

  // First requesting index at or after the pointer wins; at most one grant bit.
  always_comb begin
    int w_j;
    w_j     = 0;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      w_j = int'(i_ptr) + k;
      if (w_j >= NREQ) w_j = w_j - NREQ;
      if (!o_any && i_req[w_j]) begin
        o_any        = 1'b1;
        o_grant[w_j] = 1'b1;
        o_idx        = IDW'(w_j);
      end
    end
  end

endmodule

// File: rtl/shared_mult_sched_mult.sv
// Two-stage pipelined signed multiplier with clock enable; output is the
// low DOUT_W bits of the full-width product.
module mult_op #(
  parameter int DIN_W  = 17,
  parameter int DW_W   = 17,
  parameter int DOUT_W = 25
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_ce,
  input  logic                     i_ld,
  input  logic signed [DIN_W-1:0]  i_din,
  input  logic signed [DW_W-1:0]   i_dweight,
  output logic signed [DOUT_W-1:0] o_dout
);

  localparam int PROD_W = DIN_W + DW_W;

  logic signed [DIN_W-1:0]  r_din_p0;
  logic signed [DW_W-1:0]   r_w_p0;
  logic signed [PROD_W-1:0] w_full_p0;
  logic signed [DOUT_W-1:0] r_prod_p1;

  // Plain truncation: wrap-around is the intended behaviour, no rounding or clamping.
  function automatic logic signed [DOUT_W-1:0] trunc_prod(input logic signed [PROD_W-1:0] p);
    return DOUT_W'(p);
  endfunction

  assign w_full_p0 = $signed(PROD_W'(r_din_p0)) * $signed(PROD_W'(r_w_p0));

  // Stage 0: capture operand and weight only when a new product is accepted.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_din_p0 <= '0;
      r_w_p0   <= '0;
    end else if (i_ce && i_ld) begin
      r_din_p0 <= i_din;
      r_w_p0   <= i_dweight;
    end
  end

  // Stage 1: register the truncated product; holds while the enable is low.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prod_p1 <= '0;
    end else if (i_ce) begin
      r_prod_p1 <= trunc_prod(w_full_p0);
    end
  end

  assign o_dout = r_prod_p1;

endmodule

// File: rtl/shared_mult_sched.sv
// Shares one pipelined multiplier across NREQ channel requesters with
// round-robin arbitration, a writable per-channel weight table and id tagging.
module shared_mult_sched
  import pkg_shared_mult::*;
#(
  parameter  int NREQ  = NREQ_DEF,
  parameter  int BITS  = BITS_DEF,
  parameter  int NFRAC = NFRAC_DEF,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic [NREQ-1:0]              req_valid,
  input  logic [NREQ*BITS-1:0]         req_data,
  output logic [NREQ-1:0]              req_ready,
  input  logic                         cfg_we,
  input  logic [IDW-1:0]               cfg_idx,
  input  logic signed [BITS-1:0]       cfg_weight,
  output logic                         res_valid,
  output logic [IDW-1:0]               res_id,
  output logic signed [BITS+NFRAC-1:0] res_data,
  output logic                         busy
);

  localparam logic signed [BITS-1:0] WEIGHT_ONE = BITS'(1) << NFRAC;

  logic [IDW-1:0]          r_ptr;
  logic signed [BITS-1:0]  r_weight [NREQ];
  logic [NREQ-1:0]         w_grant;
  logic [IDW-1:0]          w_idx;
  logic                    w_any;
  logic                    w_accept;
  logic signed [BITS-1:0]  w_a;
  logic signed [BITS-1:0]  w_w;
  logic                    r_vld_p0;
  logic [IDW-1:0]          r_id_p0;
  logic                    r_vld_p1;
  logic [IDW-1:0]          r_id_p1;
  logic signed [BITS+NFRAC-1:0] w_prod;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // The grant is suppressed when frozen or in reset, so nothing is accepted then.
  assign req_ready = (en && !reset) ? w_grant : '0;
  assign w_accept  = en & ~reset & w_any;
  assign w_a       = req_data[int'(w_idx)*BITS +: BITS];
  // Combinational table read sees the pre-write value when a write hits the same index.
  assign w_w       = r_weight[w_idx];

  // Round-robin pointer moves past the winner on every accepted grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (w_accept) begin
      r_ptr <= IDW'(rr_next(int'(w_idx), NREQ));
    end
  end

  // Weight table: unity on reset; writes land even while frozen, out-of-range indices ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREQ; i++) r_weight[i] <= WEIGHT_ONE;
    end else if (cfg_we && (int'(cfg_idx) < NREQ)) begin
      r_weight[cfg_idx] <= cfg_weight;
    end
  end

  mult_op #(
    .DIN_W  (BITS),
    .DW_W   (BITS),
    .DOUT_W (BITS+NFRAC)
  ) u_mult (
    .i_clk     (clk),
    .i_rst     (reset),
    .i_ce      (en),
    .i_ld      (w_accept),
    .i_din     (w_a),
    .i_dweight (w_w),
    .o_dout    (w_prod)
  );

  // Id/valid side pipeline kept in lock-step with the multiplier stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p0 <= 1'b0;
      r_id_p0  <= '0;
      r_vld_p1 <= 1'b0;
      r_id_p1  <= '0;
    end else if (en) begin
      // Stage 0: tag of the accepted request
      r_vld_p0 <= w_accept;
      if (w_accept) r_id_p0 <= w_idx;
      // Stage 1: tag aligned with the registered product
      r_vld_p1 <= r_vld_p0;
      r_id_p1  <= r_id_p0;
    end
  end

  // A held result is hidden while frozen and shows again once enable returns.
  assign res_valid = r_vld_p1 & en;
  assign res_id    = r_id_p1;
  assign res_data  = w_prod;
  assign busy      = r_vld_p0 | r_vld_p1;

endmodule

// File: tb/tb_shared_mult_sched.sv
// Self-checking bench for shared_mult_sched: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_shared_mult_sched;

  localparam int NREQ  = 4;
  localparam int BITS  = 17;
  localparam int NFRAC = 8;
  localparam int IDW   = 2;
  localparam int RW    = BITS + NFRAC;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   en;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*BITS-1:0]   req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   cfg_we;
  logic [IDW-1:0]         cfg_idx;
  logic signed [BITS-1:0] cfg_weight;
  logic                   res_valid;
  logic [IDW-1:0]         res_id;
  logic signed [RW-1:0]   res_data;
  logic                   busy;

  logic signed [BITS-1:0] rd [NREQ];

  int nchk = 0;
  int nerr = 0;

  shared_mult_sched #(.NREQ(NREQ), .BITS(BITS), .NFRAC(NFRAC)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .cfg_we     (cfg_we),
    .cfg_idx    (cfg_idx),
    .cfg_weight (cfg_weight),
    .res_valid  (res_valid),
    .res_id     (res_id),
    .res_data   (res_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_data = '0;
    for (int i = 0; i < NREQ; i++) req_data[i*BITS +: BITS] = rd[i];
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; en = 1'b1; req_valid = '0; cfg_we = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    int          idx;
    bit          we;
    logic [16:0] w;
    logic [16:0] d;
    logic [24:0] exp;
  } vec_t;

  vec_t vecs[6];

  // Behavioural model state
  typedef struct {
    int          id;
    logic [24:0] data;
    int          age;
  } ent_t;

  ent_t                   q[$];
  int                     m_ptr;
  logic signed [BITS-1:0] m_w [NREQ];

  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (p + k) % NREQ;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{0, 1'b0, 17'h00000, 17'd5,     25'h0000500};
    vecs[1] = '{2, 1'b1, 17'h1FFFB, 17'd5,     25'h1FFFFE7};
    vecs[2] = '{1, 1'b0, 17'h00000, 17'h1FFFD, 25'h1FFFD00};
    vecs[3] = '{3, 1'b1, 17'h0FFFF, 17'h0FFFF, 25'h1FE0001};
    vecs[4] = '{0, 1'b1, 17'h10000, 17'h10000, 25'h0000000};
    vecs[5] = '{2, 1'b1, 17'h00001, 17'h1FFFF, 25'h1FFFFFF};

    reset = 1'b1; en = 1'b1; req_valid = '0; cfg_we = 1'b0; cfg_idx = '0; cfg_weight = '0;
    for (int i = 0; i < NREQ; i++) rd[i] = '0;

    // Reset state
    @(negedge clk);
    req_valid = '1;
    #1 chk("rst_ready", req_ready, 0);
    @(negedge clk);
    #1;
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_id", res_id, 0);
    chk("rst_res_data", $unsigned(res_data), 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0; req_valid = '0;

    // Directed single-transaction vectors
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (vecs[i].we) begin
        cfg_we = 1'b1; cfg_idx = IDW'(vecs[i].idx); cfg_weight = vecs[i].w;
        @(negedge clk);
        cfg_we = 1'b0;
      end
      req_valid = NREQ'(1 << vecs[i].idx);
      rd[vecs[i].idx] = vecs[i].d;
      #1 chk("vec_ready", req_ready, 64'(1) << vecs[i].idx);
      @(negedge clk);
      req_valid = '0;
      #1;
      chk("vec_early_valid", res_valid, 0);
      chk("vec_busy", busy, 1);
      @(negedge clk);
      #1;
      chk("vec_valid", res_valid, 1);
      chk("vec_id", res_id, vecs[i].idx);
      chk("vec_data", $unsigned(res_data), vecs[i].exp);
    end
    @(negedge clk);
    #1;
    chk("vec_drain_valid", res_valid, 0);
    chk("vec_drain_busy", busy, 0);

    // All requesters continuously valid: rotating grants, back-to-back results
    do_reset();
    for (int i = 0; i < NREQ; i++) rd[i] = BITS'(i + 1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      req_valid = (c < 8) ? '1 : '0;
      #1;
      if (c < 8) chk("rr_grant", req_ready, 64'(1) << (c % NREQ));
      if (c >= 2) begin
        chk("rr_res_valid", res_valid, 1);
        chk("rr_res_id", res_id, (c - 2) % NREQ);
        chk("rr_res_data", $unsigned(res_data), ((c - 2) % NREQ + 1) * 256);
      end
    end
    @(negedge clk);
    req_valid = '0;
    #1 chk("rr_after_valid", res_valid, 0);

    // Freeze with two products in flight
    do_reset();
    rd[0] = 17'd2; rd[1] = 17'd3;
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = 4'b0010;
    @(negedge clk);
    en = 1'b0; req_valid = '1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("frz_res_valid", res_valid, 0);
      chk("frz_ready", req_ready, 0);
      chk("frz_busy", busy, 1);
      @(negedge clk);
    end
    en = 1'b1; req_valid = '0;
    #1;
    chk("frz_out0_valid", res_valid, 1);
    chk("frz_out0_id", res_id, 0);
    chk("frz_out0_data", $unsigned(res_data), 512);
    @(negedge clk);
    #1;
    chk("frz_out1_valid", res_valid, 1);
    chk("frz_out1_id", res_id, 1);
    chk("frz_out1_data", $unsigned(res_data), 768);
    @(negedge clk);
    #1;
    chk("frz_end_valid", res_valid, 0);
    chk("frz_end_busy", busy, 0);

    // Same-cycle weight write and grant: old weight used, new weight next time
    do_reset();
    cfg_we = 1'b1; cfg_idx = 2'd1; cfg_weight = 17'd512;
    rd[1] = 17'd3; req_valid = 4'b0010;
    #1 chk("rbw_ready", req_ready, 4'b0010);
    @(negedge clk);
    cfg_we = 1'b0; req_valid = '0;
    @(negedge clk);
    #1;
    chk("rbw_valid", res_valid, 1);
    chk("rbw_old_w", $unsigned(res_data), 768);
    req_valid = 4'b0010;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    chk("rbw_valid2", res_valid, 1);
    chk("rbw_new_w", $unsigned(res_data), 1536);

    // Reset one cycle after an accept drops the product and restores weights
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = 2'd0; cfg_weight = 17'd1024;
    @(negedge clk);
    cfg_we = 1'b0; rd[0] = 17'd7; req_valid = 4'b0001;
    @(negedge clk);
    req_valid = '0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mrst_busy", busy, 0);
    for (int c = 0; c < 4; c++) begin
      chk("mrst_no_valid", res_valid, 0);
      @(negedge clk);
      #1;
    end
    rd[0] = 17'd1; req_valid = 4'b0001;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    chk("mrst_valid", res_valid, 1);
    chk("mrst_weight", $unsigned(res_data), 256);

    // Randomized run against the behavioural model
    do_reset();
    q.delete();
    m_ptr = 0;
    for (int i = 0; i < NREQ; i++) m_w[i] = 17'sd256;
    for (int cyc = 0; cyc < 600; cyc++) begin
      int g;
      bit exp_v;
      @(negedge clk);
      en         = ($urandom_range(0, 9) != 0);
      req_valid  = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) rd[i] = BITS'($urandom);
      cfg_we     = ($urandom_range(0, 5) == 0);
      cfg_idx    = IDW'($urandom);
      cfg_weight = BITS'($urandom);
      #1;
      g = en ? pick(req_valid, m_ptr) : -1;
      chk("rnd_ready", req_ready, (g >= 0) ? (64'(1) << g) : 64'(0));
      exp_v = en && (q.size() > 0) && (q[0].age == 1);
      chk("rnd_res_valid", res_valid, exp_v);
      chk("rnd_busy", busy, q.size() != 0);
      if (exp_v) begin
        chk("rnd_res_id", res_id, q[0].id);
        chk("rnd_res_data", $unsigned(res_data), q[0].data);
      end
      @(posedge clk);
      if (en) begin
        if (q.size() > 0 && q[0].age == 1) void'(q.pop_front());
        foreach (q[i]) q[i].age++;
        if (g >= 0) begin
          longint p;
          ent_t e;
          p      = longint'(rd[g]) * longint'(m_w[g]);
          e.id   = g;
          e.data = p[24:0];
          e.age  = 0;
          q.push_back(e);
          m_ptr = (g + 1) % NREQ;
        end
      end
      if (cfg_we) m_w[cfg_idx] = cfg_weight;
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
